// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings as presented on the op port
//   - FSM state enum
//   - width-generic two's-complement conditional negate (absolute value when
//     the enable is the operand's sign bit)
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  // Widest value the helper handles; callers zero-extend into it and truncate
  // back. The low k bits of a negation do not depend on the working width, so
  // this is exact for any 2*WIDTH <= MDU_MAXW.
  localparam int MDU_MAXW = 128;

  function automatic logic [MDU_MAXW-1:0] mdu_cond_neg(input logic [MDU_MAXW-1:0] x,
                                                       input logic               en);
    return en ? (~x + MDU_MAXW'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit_core.sv
// mdu_iter_core: per-step datapath for the multi-cycle multiply/divide.
//   clk, reset     : clock, synchronous active-low reset
//   load_i         : load operands and iteration counter (PREP)
//   run_i          : perform one step this cycle (RUN)
//   is_div_i       : 1 = restoring divide step, 0 = shift-add multiply step
//   opa_i, opb_i   : unsigned operand magnitudes (a, b)
//   last_o         : counter is at 0, current step is the final one
//   acc_hi_o/lo_o  : accumulator halves (product hi/lo, or remainder/quotient)
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             last_o,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   add_sum, shifted, diff;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // Partial remainder shifted left with the next dividend bit brought in.
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, m_q};
    if (load_i) begin
      hi_d  = '0;
      lo_d  = is_div_i ? opa_i : opb_i;
      m_d   = is_div_i ? opb_i : opa_i;
      cnt_d = CW'(WIDTH-1);
    end else if (run_i) begin
      cnt_d = cnt_q - CW'(1);
      if (!is_div_i) begin
        // Carry out of the add lands in the top bit after the right shift.
        {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o   = (cnt_q == '0);
  assign acc_hi_o = hi_q;
  assign acc_lo_o = lo_q;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide producing HI/LO.
//   clk, reset : clock, synchronous active-low reset
//   start      : request an operation (accepted only when busy = 0)
//   op         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       : operands, latched on an accepted start
//   busy       : operation in progress (PREP/RUN/FIX)
//   done       : one-cycle pulse, hi/lo/div_zero valid
//   hi, lo     : product halves, or remainder/quotient
//   div_zero   : last divide had b == 0
// WIDTH must be at least 4 and at most MDU_MAXW/2.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  mdu_state_e       state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             div_zero_q, neg_res_q, neg_rem_q;

  logic             is_div, is_signed, accept, div_by_zero, core_last;
  logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_div      = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed   = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign accept      = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign div_by_zero = is_div && (b_q == '0);

  // Unsigned magnitudes fed to the core; unsigned ops pass straight through.
  assign mag_a = WIDTH'(mdu_cond_neg(MDU_MAXW'(a_q), is_signed && a_q[WIDTH-1]));
  assign mag_b = WIDTH'(mdu_cond_neg(MDU_MAXW'(b_q), is_signed && b_q[WIDTH-1]));

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_q == ST_PREP),
    .run_i    (state_q == ST_RUN),
    .is_div_i (is_div),
    .opa_i    (mag_a),
    .opb_i    (mag_b),
    .last_o   (core_last),
    .acc_hi_o (acc_hi),
    .acc_lo_o (acc_lo)
  );

  // Sign correction. neg_res_q/neg_rem_q are only ever set for signed ops.
  // Most-negative / -1 yields quotient magnitude 2^(WIDTH-1) with no negation,
  // which reads back as the most-negative value (wrap).
  always_comb begin
    prod_fix = (2*WIDTH)'(mdu_cond_neg(MDU_MAXW'({acc_hi, acc_lo}), neg_res_q));
    if (is_div) begin
      fix_lo = WIDTH'(mdu_cond_neg(MDU_MAXW'(acc_lo), neg_res_q));
      fix_hi = WIDTH'(mdu_cond_neg(MDU_MAXW'(acc_hi), neg_rem_q));
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = accept ? ST_PREP : ST_IDLE;
      ST_PREP:          state_d = div_by_zero ? ST_DONE : ST_RUN;
      ST_RUN:           state_d = core_last ? ST_FIX : ST_RUN;
      ST_FIX:           state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_PREP, ST_RUN, ST_FIX: busy = 1'b1;
      ST_DONE:                 done = 1'b1;
      default: ;
    endcase
  end

  // Operand latch and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op;
        a_q        <= a;
        b_q        <= b;
        div_zero_q <= 1'b0;
      end
      if (state_q == ST_PREP) begin
        neg_res_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_q <= is_signed && a_q[WIDTH-1];
        if (div_by_zero) begin
          hi_q       <= a_q;
          lo_q       <= '1;
          div_zero_q <= 1'b1;
        end
      end
      if (state_q == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
